// File: rtl/mem_pkg.sv
// Shared types and defaults for the parametrised data memory.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  localparam int DEF_DATA_W      = 32;
  localparam int DEF_DEPTH       = 128;
  localparam int DEF_ADDR_W      = 32;
  localparam int DEF_WAIT_STATES = 2;

  // Number of byte-offset bits inside one word.
  function automatic int ofs_of(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/mem_byte_lane_ram.sv
// Word-organised storage with per-byte-lane write enables and a registered read port.
module mem_byte_lane_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 128,
  parameter int AW     = 7
) (
  input  logic                clk,
  input  logic [DATA_W/8-1:0] we,
  input  logic                re,
  input  logic [AW-1:0]       addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage is deliberately not reset; the read register holds until the next read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (we[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/param_data_memory.sv
// Single-port data memory with programmable wait states and ACK handshake.
// Define MEM_ALIGN_CHECK_EN to add the ERR port and suppress misaligned accesses.
module param_data_memory
  import mem_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int WAIT_STATES = DEF_WAIT_STATES
) (
  input  logic                ClK,
  input  logic                RST,
  input  logic                CS,
  input  logic                WE,
  input  logic [DATA_W/8-1:0] BE,
  input  logic [ADDR_W-1:0]   ADDR,
  input  logic [DATA_W-1:0]   WDATA,
  output logic [DATA_W-1:0]   RDATA,
  output logic                ACK,
  output logic                BUSY
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic                ERR
`endif
);

  localparam int NB  = DATA_W / 8;
  localparam int OFS = ofs_of(DATA_W);
  localparam int IW  = ADDR_W - OFS;
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IW-1:0]     DEPTH_IDX  = IW'(DEPTH);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(NB - 1);

  mem_state_t          state, state_nxt;
  logic [3:0]          cnt, cnt_nxt;
  logic                lat_we;
  logic [NB-1:0]       lat_be;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic                rdata_zero;
  logic [DATA_W-1:0]   ram_rdata;

  logic                acc_we;
  logic [NB-1:0]       acc_be;
  logic [ADDR_W-1:0]   acc_addr;
  logic [DATA_W-1:0]   acc_wdata;
  logic [IW-1:0]       acc_idx;
  logic                access_go, in_range, misaligned, unused_lo;
  logic [NB-1:0]       ram_we;
  logic                ram_re;

  always_ff @(posedge ClK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_we    <= 1'b0;
      lat_be    <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == IDLE && CS) begin
        lat_we    <= WE;
        lat_be    <= BE;
        lat_addr  <= ADDR;
        lat_wdata <= WDATA;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (CS) begin
          cnt_nxt   = 4'(WAIT_STATES);
          state_nxt = (WAIT_STATES > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // With zero wait states the access happens on the accept edge, so use the live bus.
  always_comb begin
    if (state == IDLE) begin
      acc_we    = WE;
      acc_be    = BE;
      acc_addr  = ADDR;
      acc_wdata = WDATA;
    end else begin
      acc_we    = lat_we;
      acc_be    = lat_be;
      acc_addr  = lat_addr;
      acc_wdata = lat_wdata;
    end
  end

  assign acc_idx   = acc_addr[ADDR_W-1:OFS];
  assign in_range  = (acc_idx < DEPTH_IDX);
  assign access_go = (state_nxt == RESP) && !RST;
  assign unused_lo = |(acc_addr & ALIGN_MASK);

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = unused_lo;
`else
  assign misaligned = 1'b0;
`endif

  assign ram_we = (access_go && acc_we && in_range && !misaligned) ? acc_be : '0;
  assign ram_re = access_go && !acc_we && in_range && !misaligned;

  mem_byte_lane_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk   (ClK),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (acc_idx[AW-1:0]),
    .wdata (acc_wdata),
    .rdata (ram_rdata)
  );

  // Out-of-range reads return zero by masking the held RAM output.
  always_ff @(posedge ClK or posedge RST) begin
    if (RST) rdata_zero <= 1'b1;
    else if (access_go && !acc_we && !misaligned) rdata_zero <= !in_range;
  end

  assign RDATA = rdata_zero ? '0 : ram_rdata;
  assign ACK   = (state == RESP);
  assign BUSY  = (state != IDLE);

`ifdef MEM_ALIGN_CHECK_EN
  logic err_q;
  always_ff @(posedge ClK or posedge RST) begin
    if (RST) err_q <= 1'b0;
    else     err_q <= access_go && misaligned;
  end
  assign ERR = err_q;
`endif

endmodule

// File: tb/tb_param_data_memory.sv
// Directed table-driven bench for param_data_memory (WAIT_STATES=2).
module tb_param_data_memory;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          cs;
  logic          we;
  logic [3:0]    be;
  logic [W-1:0]  addr;
  logic [W-1:0]  wdata;
  logic [W-1:0]  rdata;
  logic          ack;
  logic          busy;
`ifdef MEM_ALIGN_CHECK_EN
  logic          err;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int ack_cnt  = 0;
  int cyc      = 0;
  int ack_cyc_q[$];
  logic [W-1:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (ack) begin
    ack_cnt++;
    ack_cyc_q.push_back(cyc);
  end

  param_data_memory #(
    .DATA_W(32), .DEPTH(128), .ADDR_W(32), .WAIT_STATES(2)
  ) dut (
    .ClK   (clk),
    .RST   (rst),
    .CS    (cs),
    .WE    (we),
    .BE    (be),
    .ADDR  (addr),
    .WDATA (wdata),
    .RDATA (rdata),
    .ACK   (ack),
    .BUSY  (busy)
`ifdef MEM_ALIGN_CHECK_EN
    ,
    .ERR   (err)
`endif
  );

  typedef struct {
    logic         we;
    logic [3:0]   be;
    logic [W-1:0] addr;
    logic [W-1:0] wdata;
    logic [W-1:0] exp_rdata;
  } vec_t;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_bus();
    cs = 1'b0; we = 1'b0; be = '0; addr = '0; wdata = '0;
  endtask

  // Latency = posedges from the accept edge (inclusive) until ACK is seen high.
  task automatic do_txn(input logic w, input logic [3:0] b, input logic [W-1:0] a,
                        input logic [W-1:0] d, output logic [W-1:0] rd,
                        output int lat, output logic e);
    @(negedge clk);
    cs = 1'b1; we = w; be = b; addr = a; wdata = d;
    @(posedge clk);
    @(negedge clk);
    idle_bus();
    check("busy_after_accept", W'(busy), 1);
    lat = 1;
    while (!ack && lat < 16) begin
      @(negedge clk);
      lat++;
    end
    rd = rdata;
`ifdef MEM_ALIGN_CHECK_EN
    e = err;
`else
    e = 1'b0;
`endif
    @(negedge clk);
    check("ack_one_cycle", W'(ack), 0);
    check("busy_after_ack", W'(busy), 0);
  endtask

  vec_t         vecs[14];
  logic [W-1:0] rd;
  logic         e;
  int           lat;
  int           base;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b1, 4'b1111, 32'h010, 32'hDEADBEEF, 32'h00000000};
    vecs[1]  = '{1'b0, 4'b1111, 32'h010, 32'h0,        32'hDEADBEEF};
    vecs[2]  = '{1'b1, 4'b1111, 32'h020, 32'h11223344, 32'hDEADBEEF};
    vecs[3]  = '{1'b1, 4'b0101, 32'h020, 32'hAABBCCDD, 32'hDEADBEEF};
    vecs[4]  = '{1'b0, 4'b0000, 32'h020, 32'h0,        32'h11BB33DD};
    vecs[5]  = '{1'b1, 4'b1111, 32'h000, 32'hCAFEF00D, 32'h11BB33DD};
    vecs[6]  = '{1'b0, 4'b1111, 32'h200, 32'h0,        32'h00000000};
    vecs[7]  = '{1'b1, 4'b1111, 32'h200, 32'hFFFFFFFF, 32'h00000000};
    vecs[8]  = '{1'b0, 4'b1111, 32'h000, 32'h0,        32'hCAFEF00D};
    vecs[9]  = '{1'b1, 4'b1111, 32'h008, 32'h0BADC0DE, 32'hCAFEF00D};
    vecs[10] = '{1'b1, 4'b0000, 32'h008, 32'hFFFFFFFF, 32'hCAFEF00D};
    vecs[11] = '{1'b0, 4'b1111, 32'h008, 32'h0,        32'h0BADC0DE};
    vecs[12] = '{1'b1, 4'b1111, 32'h1FC, 32'h76543210, 32'h0BADC0DE};
    vecs[13] = '{1'b0, 4'b1111, 32'h1FC, 32'h0,        32'h76543210};

    rst = 1'b1;
    idle_bus();
    repeat (3) @(negedge clk);
    check("reset_rdata", rdata, 0);
    check("reset_ack", W'(ack), 0);
    check("reset_busy", W'(busy), 0);
`ifdef MEM_ALIGN_CHECK_EN
    check("reset_err", W'(err), 0);
`endif
    rst = 1'b0;

    // Table: every transaction checks latency and RDATA (held value on writes).
    for (int i = 0; i < 14; i++) begin
      exp_q.push_back(vecs[i].exp_rdata);
      do_txn(vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata, rd, lat, e);
      check($sformatf("vec%0d_latency", i), W'(lat), 3);
      check($sformatf("vec%0d_rdata", i), rd, exp_q.pop_front());
`ifdef MEM_ALIGN_CHECK_EN
      check($sformatf("vec%0d_err", i), W'(e), 0);
`endif
    end

    // CS during BUSY with a conflicting write must be ignored.
    base = ack_cnt;
    @(negedge clk);
    cs = 1'b1; we = 1'b0; be = 4'hF; addr = 32'h010; wdata = '0;
    @(posedge clk);
    @(negedge clk);
    we = 1'b1; addr = 32'h020; wdata = 32'h0;
    lat = 1;
    while (!ack && lat < 16) begin
      @(negedge clk);
      lat++;
    end
    check("busy_cs_latency", W'(lat), 3);
    check("busy_cs_rdata", rdata, 32'hDEADBEEF);
    idle_bus();
    repeat (8) @(negedge clk);
    check("busy_cs_ack_count", W'(ack_cnt - base), 1);
    do_txn(1'b0, 4'hF, 32'h020, 32'h0, rd, lat, e);
    check("busy_cs_no_write", rd, 32'h11BB33DD);

    // CS held high: accepts spaced by WAIT_STATES+2 cycles.
    ack_cyc_q.delete();
    @(negedge clk);
    cs = 1'b1; we = 1'b0; be = 4'hF; addr = 32'h010;
    repeat (12) @(negedge clk);
    idle_bus();
    repeat (8) @(negedge clk);
    if (ack_cyc_q.size() >= 2)
      check("throughput_period", W'(ack_cyc_q[1] - ack_cyc_q[0]), 4);
    else
      check("throughput_ack_count", W'(ack_cyc_q.size()), 2);
    check("throughput_rdata", rdata, 32'hDEADBEEF);

    // Reset during WAIT of a write abandons it.
    base = ack_cnt;
    @(negedge clk);
    cs = 1'b1; we = 1'b1; be = 4'hF; addr = 32'h008; wdata = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    idle_bus();
    check("rst_mid_busy_before", W'(busy), 1);
    rst = 1'b1;
    #1;
    check("rst_mid_ack", W'(ack), 0);
    check("rst_mid_busy", W'(busy), 0);
    check("rst_mid_rdata", rdata, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("rst_mid_no_ack", W'(ack_cnt - base), 0);
    do_txn(1'b0, 4'hF, 32'h008, 32'h0, rd, lat, e);
    check("rst_mid_no_write", rd, 32'h0BADC0DE);
    check("rst_mid_read_latency", W'(lat), 3);

    // Misaligned write.
    do_txn(1'b1, 4'hF, 32'h012, 32'h55667788, rd, lat, e);
    check("misaligned_latency", W'(lat), 3);
`ifdef MEM_ALIGN_CHECK_EN
    check("misaligned_err", W'(e), 1);
    check("misaligned_rdata_held", rd, 32'h0BADC0DE);
    do_txn(1'b0, 4'hF, 32'h010, 32'h0, rd, lat, e);
    check("misaligned_no_write", rd, 32'hDEADBEEF);
    check("aligned_err_clear", W'(e), 0);
`else
    do_txn(1'b0, 4'hF, 32'h010, 32'h0, rd, lat, e);
    check("truncated_write_word4", rd, 32'h55667788);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
